// File: rtl/avmm_mem_pkg.sv
// avmm_mem_pkg: shared definitions for the Avalon-MM responder memory.
//   be_width()   - byte-lane count for a data width
//   lane_shift() - address shift from byte address to word index
//   POISON64     - value returned for out-of-range reads (truncated to DATA_W)
//   word_idx_t   - full-width aligned word index, before bounds checking
//   acc_t        - decoded per-cycle access request
package avmm_mem_pkg;

   localparam int          ADDR_W   = 64;
   localparam logic [63:0] POISON64 = 64'hDEAD_BEEF_DEAD_BEEF;

   typedef logic [ADDR_W-1:0] word_idx_t;

   typedef struct packed {
      logic rd;        // read accepted (read without a colliding write)
      logic wr;        // write request seen
      logic oob;       // address outside the array
      logic misalign;  // low address bits nonzero
   } acc_t;

   function automatic int be_width(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int lane_shift(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/avmm_rd_delay_pipe.sv
// avmm_rd_delay_pipe: fixed-latency valid+data shift register.
//   clock     in   rising-edge clock
//   clear     in   synchronous clear of all valids and data
//   in_valid  in   entry enters stage 0 at this edge
//   in_data   in   W-bit data for the entry
//   out_valid out  entry leaving the last stage, LATENCY edges after entry
//   out_data  out  data of the most recent entry to reach the last stage
// Each data stage only loads when a valid entry moves into it, so the
// output holds its last result while no new one is emerging.
module avmm_rd_delay_pipe #(
   parameter int W       = 64,
   parameter int LATENCY = 1
) (
   input  logic         clock,
   input  logic         clear,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   localparam int STAGES = LATENCY - 1;

   logic [STAGES:0]        vld_pipe;
   logic [STAGES:0][W-1:0] dat_pipe;

   always_ff @(posedge clock) begin
      if (clear) begin
         vld_pipe <= '0;
         dat_pipe <= '0;
      end else begin
         vld_pipe[0] <= in_valid;
         if (in_valid) dat_pipe[0] <= in_data;
         for (int k = 1; k <= STAGES; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
         end
      end
   end

   assign out_valid = vld_pipe[STAGES];
   assign out_data  = dat_pipe[STAGES];

endmodule

// File: rtl/avmm_rw_mem_responder.sv
// avmm_rw_mem_responder: never-stalling Avalon-MM responder memory.
//   clock, reset            rising-edge clock, synchronous active-high reset
//   avmm_address            byte address (BASE_ADDR maps to word 0)
//   avmm_read/avmm_write    one access per cycle; read+write together keeps the write
//   avmm_byteenable         per-byte write enables
//   avmm_writedata          write data
//   avmm_readdata, rd_valid read result READ_LATENCY cycles after the request
//   bd_we/bd_index/bd_wdata backdoor full-word write
//   bd_rdata                backdoor registered read (pre-write value)
//   err_oob/err_proto/err_misalign  sticky error flags
//   rd_count/wr_count       accepted access counters, wrap modulo 2^32
// The array itself is never reset; only control, counters and flags are.
module avmm_rw_mem_responder
   import avmm_mem_pkg::*;
#(
   parameter int          DATA_W       = 64,
   parameter int          DEPTH_LOG2   = 12,
   parameter logic [63:0] BASE_ADDR    = 64'h0,
   parameter int          READ_LATENCY = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [63:0]                   avmm_address,
   input  logic [be_width(DATA_W)-1:0]   avmm_byteenable,
   input  logic                          avmm_read,
   output logic [DATA_W-1:0]             avmm_readdata,
   input  logic                          avmm_write,
   input  logic [DATA_W-1:0]             avmm_writedata,
   output logic                          rd_valid,
   input  logic                          bd_we,
   input  logic [DEPTH_LOG2-1:0]         bd_index,
   input  logic [DATA_W-1:0]             bd_wdata,
   output logic [DATA_W-1:0]             bd_rdata,
   output logic                          err_oob,
   output logic                          err_proto,
   output logic                          err_misalign,
   output logic [31:0]                   rd_count,
   output logic [31:0]                   wr_count
);

   localparam int                BE_W     = be_width(DATA_W);
   localparam int                SH       = lane_shift(DATA_W);
   localparam int                DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [63:0]       LOW_MASK = 64'(BE_W - 1);
   localparam logic [DATA_W-1:0] POISON   = DATA_W'(POISON64);

   typedef logic [BE_W-1:0][7:0] word_t;

   word_t                 mem [DEPTH];
   logic [63:0]           off;
   word_idx_t             idx_full;
   logic [DEPTH_LOG2-1:0] idx;
   acc_t                  acc;
   logic                  wr_ok;
   logic                  bd_lost;
   logic [DATA_W-1:0]     rd_word;

   // Decode: misaligned accesses still proceed at the aligned-down index.
   always_comb begin
      off          = avmm_address - BASE_ADDR;
      idx_full     = off >> SH;
      idx          = idx_full[DEPTH_LOG2-1:0];
      acc.rd       = avmm_read & ~avmm_write & ~reset;
      acc.wr       = avmm_write & ~reset;
      acc.oob      = (avmm_address < BASE_ADDR) || ((idx_full >> DEPTH_LOG2) != '0);
      acc.misalign = (avmm_address & LOW_MASK) != '0;
   end

   assign wr_ok   = acc.wr & ~acc.oob;
   // An Avalon write to the same word wins over the backdoor outright,
   // including lanes the Avalon write leaves disabled.
   assign bd_lost = wr_ok && (idx == bd_index);
   assign rd_word = acc.oob ? POISON : mem[idx];

   always_ff @(posedge clock) begin
      if (bd_we && !bd_lost) mem[bd_index] <= bd_wdata;
      if (wr_ok) begin
         for (int b = 0; b < BE_W; b++)
            if (avmm_byteenable[b]) mem[idx][b] <= avmm_writedata[b*8 +: 8];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) bd_rdata <= '0;
      else       bd_rdata <= mem[bd_index];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         err_oob      <= 1'b0;
         err_proto    <= 1'b0;
         err_misalign <= 1'b0;
         rd_count     <= '0;
         wr_count     <= '0;
      end else begin
         if ((acc.rd | acc.wr) & acc.oob)      err_oob      <= 1'b1;
         if (avmm_read & avmm_write)           err_proto    <= 1'b1;
         if ((acc.rd | acc.wr) & acc.misalign) err_misalign <= 1'b1;
         if (acc.rd) rd_count <= rd_count + 32'd1;
         if (wr_ok)  wr_count <= wr_count + 32'd1;
      end
   end

   avmm_rd_delay_pipe #(
      .W       (DATA_W),
      .LATENCY (READ_LATENCY)
   ) u_rd_pipe (
      .clock     (clock),
      .clear     (reset),
      .in_valid  (acc.rd),
      .in_data   (rd_word),
      .out_valid (rd_valid),
      .out_data  (avmm_readdata)
   );

endmodule

// File: tb/tb_avmm_rw_mem_responder.sv
module tb_avmm_rw_mem_responder;

   localparam int          DW  = 64;
   localparam int          DL2 = 4;
   localparam int          LAT = 3;
   localparam int          NW  = 16;
   localparam logic [63:0] POISON = 64'hDEAD_BEEF_DEAD_BEEF;

   logic          clock = 1'b0;
   logic          reset;
   logic [63:0]   avmm_address;
   logic [7:0]    avmm_byteenable;
   logic          avmm_read, avmm_write;
   logic [DW-1:0] avmm_readdata, avmm_writedata;
   logic          rd_valid;
   logic          bd_we;
   logic [DL2-1:0] bd_index;
   logic [DW-1:0] bd_wdata, bd_rdata;
   logic          err_oob, err_proto, err_misalign;
   logic [31:0]   rd_count, wr_count;

   always #5 clock = ~clock;

   avmm_rw_mem_responder #(
      .DATA_W(DW), .DEPTH_LOG2(DL2), .BASE_ADDR(64'h0), .READ_LATENCY(LAT)
   ) dut (
      .clock(clock), .reset(reset),
      .avmm_address(avmm_address), .avmm_byteenable(avmm_byteenable),
      .avmm_read(avmm_read), .avmm_readdata(avmm_readdata),
      .avmm_write(avmm_write), .avmm_writedata(avmm_writedata),
      .rd_valid(rd_valid),
      .bd_we(bd_we), .bd_index(bd_index), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata),
      .err_oob(err_oob), .err_proto(err_proto), .err_misalign(err_misalign),
      .rd_count(rd_count), .wr_count(wr_count)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model: word array, queue of pending read results with due cycle.
   typedef struct { int due; logic [63:0] data; } pend_t;
   logic [63:0] m_mem [NW];
   pend_t       pend [$];
   int          cyc = 0;
   logic        m_rd_valid = 1'b0;
   logic [63:0] m_rdata = '0, m_bd_rdata = '0;
   logic        m_oob = 1'b0, m_proto = 1'b0, m_mis = 1'b0;
   logic [31:0] m_rdc = '0, m_wrc = '0;
   bit          chk_en = 1'b0, bd_known = 1'b0;
   logic [63:0] seen [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      logic [63:0] a;
      int          idx;
      bit          oob, rd, wr;
      cyc++;
      if (reset) begin
         pend.delete();
         m_rd_valid = 0; m_rdata = '0; m_bd_rdata = '0;
         m_oob = 0; m_proto = 0; m_mis = 0; m_rdc = '0; m_wrc = '0;
         chk_en = 1'b1;
         return;
      end
      a   = avmm_address;
      oob = (a >= 64'(NW * 8));
      idx = oob ? 0 : int'(a >> 3);
      rd  = avmm_read && !avmm_write;
      wr  = avmm_write;
      m_bd_rdata = m_mem[bd_index];
      if (rd) begin
         pend.push_back('{due: cyc + LAT - 1, data: (oob ? POISON : m_mem[idx])});
         m_rdc++;
      end
      if (avmm_read && avmm_write) m_proto = 1;
      if ((rd || wr) && oob) m_oob = 1;
      if ((rd || wr) && a[2:0] != 3'd0) m_mis = 1;
      if (bd_we && !(wr && !oob && idx == int'(bd_index))) m_mem[bd_index] = bd_wdata;
      if (wr && !oob) begin
         for (int b = 0; b < 8; b++)
            if (avmm_byteenable[b]) m_mem[idx][8*b +: 8] = avmm_writedata[8*b +: 8];
         m_wrc++;
      end
      m_rd_valid = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         m_rd_valid = 1;
         m_rdata    = pend[0].data;
         void'(pend.pop_front());
      end
   endtask

   // Compare every cycle once reset has been applied.
   always @(negedge clock) begin
      if (chk_en) begin
         chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
         chk("readdata", avmm_readdata, m_rdata);
         if (bd_known) chk("bd_rdata", bd_rdata, m_bd_rdata);
         chk("err_oob", 64'(err_oob), 64'(m_oob));
         chk("err_proto", 64'(err_proto), 64'(m_proto));
         chk("err_misalign", 64'(err_misalign), 64'(m_mis));
         chk("rd_count", 64'(rd_count), 64'(m_rdc));
         chk("wr_count", 64'(wr_count), 64'(m_wrc));
      end
   end

   task automatic step();
      @(posedge clock);
      model_update();
      @(negedge clock);
      if (rd_valid) seen.push_back(avmm_readdata);
   endtask

   task automatic drain(input int n);
      repeat (n) step();
   endtask

   task automatic rd(input logic [63:0] a);
      avmm_address = a; avmm_read = 1'b1;
      step();
      avmm_read = 1'b0;
   endtask

   task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
      avmm_address = a; avmm_writedata = d; avmm_byteenable = be; avmm_write = 1'b1;
      step();
      avmm_write = 1'b0;
   endtask

   task automatic bdw(input logic [DL2-1:0] i, input logic [63:0] d);
      bd_index = i; bd_wdata = d; bd_we = 1'b1;
      step();
      bd_we = 1'b0;
   endtask

   task automatic chk_one(input string name, input logic [63:0] exp);
      chk({name, "_count"}, 64'(seen.size()), 64'd1);
      if (seen.size() > 0) chk(name, seen[0], exp);
   endtask

   initial begin
      reset = 1'b1; avmm_read = 0; avmm_write = 0; avmm_byteenable = '0;
      avmm_address = '0; avmm_writedata = '0; bd_we = 0; bd_index = '0; bd_wdata = '0;
      for (int i = 0; i < NW; i++) m_mem[i] = '0;
      drain(2);
      chk("rst_readdata", avmm_readdata, 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_rd_count", 64'(rd_count), 64'd0);
      chk("rst_flags", 64'({err_oob, err_proto, err_misalign}), 64'd0);
      reset = 1'b0;
      for (int i = 0; i < NW; i++) bdw(DL2'(i), 64'd0);
      bd_index = '0; step(); bd_known = 1'b1;

      // Back-to-back reads of backdoor-loaded words
      bdw(0, 64'd1); bdw(1, 64'd2); bdw(2, 64'd3); bdw(3, 64'd4);
      seen.delete();
      rd(64'h0); rd(64'h8); rd(64'h10); rd(64'h18);
      drain(4);
      chk("t1_count", 64'(seen.size()), 64'd4);
      for (int i = 0; i < 4; i++)
         if (i < seen.size()) chk("t1_data", seen[i], 64'(i + 1));
      chk("t1_rd_count", 64'(rd_count), 64'd4);

      // Byte-enabled write, zero-enable no-op, backdoor collision
      bdw(5, 64'h1111_2222_3333_4444);
      wr(64'h28, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
      seen.delete(); rd(64'h28); drain(3);
      chk_one("t2_be", 64'h1111_2222_CCCC_DDDD);
      chk("t2_wr_count", 64'(wr_count), 64'd1);
      wr(64'h28, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
      chk("t2_be0_count", 64'(wr_count), 64'd2);
      bd_index = 5; step();
      chk("t2_peek", bd_rdata, 64'h1111_2222_CCCC_DDDD);
      bd_index = 6; bd_wdata = 64'h99; bd_we = 1'b1;
      wr(64'h30, 64'h77, 8'hFF);
      bd_we = 1'b0;
      seen.delete(); rd(64'h30); drain(3);
      chk_one("t2_bd_conflict", 64'h77);

      // Write then read, latency, read+write collision
      wr(64'h40, 64'h55, 8'hFF);
      seen.delete(); rd(64'h40);
      step(); chk("t3_lat_early", 64'(rd_valid), 64'd0);
      step(); chk("t3_lat_hit", 64'(rd_valid), 64'd1);
      chk("t3_data", avmm_readdata, 64'h55);
      chk("t3_proto_before", 64'(err_proto), 64'd0);
      seen.delete(); avmm_read = 1'b1;
      wr(64'h40, 64'h66, 8'hFF);
      avmm_read = 1'b0; drain(4);
      chk("t3_proto", 64'(err_proto), 64'd1);
      chk("t3_no_valid", 64'(seen.size()), 64'd0);
      seen.delete(); rd(64'h40); drain(3);
      chk_one("t3_after", 64'h66);

      // Out of bounds and misalignment
      chk("t4_oob_before", 64'(err_oob), 64'd0);
      seen.delete(); rd(64'h80); drain(3);
      chk_one("t4_poison", POISON);
      chk("t4_oob", 64'(err_oob), 64'd1);
      wr(64'h80, 64'h1234, 8'hFF);
      seen.delete(); rd(64'h0); drain(3);
      chk_one("t4_idx0", 64'd1);
      chk("t4_mis_before", 64'(err_misalign), 64'd0);
      seen.delete(); rd(64'h0C); drain(3);
      chk_one("t4_misalign_data", 64'd2);
      chk("t4_mis", 64'(err_misalign), 64'd1);

      // Reset with reads in flight
      seen.delete(); rd(64'h0); rd(64'h8);
      reset = 1'b1; step(); reset = 1'b0;
      drain(6);
      chk("t5_no_valid", 64'(seen.size()), 64'd0);
      chk("t5_rd_count", 64'(rd_count), 64'd0);
      chk("t5_wr_count", 64'(wr_count), 64'd0);
      chk("t5_flags", 64'({err_oob, err_proto, err_misalign}), 64'd0);
      chk("t5_readdata", avmm_readdata, 64'd0);
      seen.delete(); rd(64'h10); rd(64'h28); drain(4);
      chk("t5_intact_count", 64'(seen.size()), 64'd2);
      if (seen.size() > 1) begin
         chk("t5_intact_a", seen[0], 64'd3);
         chk("t5_intact_b", seen[1], 64'h1111_2222_CCCC_DDDD);
      end

      // Counter wrap
      @(posedge clock); model_update(); #1;
      force dut.rd_count = 32'hFFFF_FFFF;
      m_rdc = 32'hFFFF_FFFF;
      @(negedge clock);
      @(posedge clock); model_update(); #1;
      release dut.rd_count;
      @(negedge clock);
      chk("t6_pre", 64'(rd_count), 64'h0000_0000_FFFF_FFFF);
      seen.delete(); rd(64'h18);
      chk("t6_wrap", 64'(rd_count), 64'd0);
      drain(3);
      chk_one("t6_data", 64'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
